// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-I core: field widths, opcodes, FSM states and ALU ops.
package bip_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam int OPC_W  = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB
  } alu_op_t;

endpackage

// File: rtl/bip_alu.sv
// Combinational accumulator ALU; PASS forwards the operand so LD/LDI share the ACC write path.
module bip_alu
  import bip_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  alu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  always_comb begin
    result = b;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/bip_cpu.sv
// Multi-cycle BIP-I core: fetch / decode / execute / memory-wait, accumulator machine.
// state    | meaning
// S_FETCH  | PROG_ADDR=PC presented to the synchronous ROM
// S_DECODE | ROM word valid, latched into IR
// S_EXEC   | execute by opcode; LD/ADD/SUB issue DM_RD
// S_MEM    | DM_OUT_DATA valid, combined into ACC
// S_HALT   | absorbing until RESET
module bip_cpu
  import bip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int OPC_W  = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_DATA,
  output logic              DM_RD,
  output logic              DM_WR,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [DATA_W-1:0] DM_IN_DATA,
  input  logic [DATA_W-1:0] DM_OUT_DATA,
  output logic [DATA_W-1:0] ACC,
  output logic              HALTED,
  output logic [15:0]       CYCLE_CNT
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir, acc, sext, alu_b, alu_y;
  logic [15:0]       cycle_cnt;
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] operand;
  alu_op_t           alu_op;
  logic              ir_we, acc_we, pc_inc, dm_rd, dm_wr;

  assign opc     = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[ADDR_W-1:0];
  assign sext    = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};

  bip_alu #(.W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (acc),
    .b      (alu_b),
    .result (alu_y)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ir_we)  ir  <= PROG_DATA;
      if (acc_we) acc <= alu_y;
      if (pc_inc) pc  <= pc + 1'b1;
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  // Strobes depend only on state and IR, so an async reset drops them at once.
  always_comb begin
    state_nxt = state;
    ir_we     = 1'b0;
    acc_we    = 1'b0;
    pc_inc    = 1'b0;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    alu_op    = ALU_PASS;
    alu_b     = sext;
    unique case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        ir_we     = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
        case (opc)
          OP_HLT: begin
            pc_inc    = 1'b0;
            state_nxt = S_HALT;
          end
          OP_STO: dm_wr = 1'b1;
          OP_LD, OP_ADD, OP_SUB: begin
            dm_rd     = 1'b1;
            pc_inc    = 1'b0;
            state_nxt = S_MEM;
          end
          OP_LDI:  acc_we = 1'b1;
          OP_ADDI: begin
            acc_we = 1'b1;
            alu_op = ALU_ADD;
          end
          OP_SUBI: begin
            acc_we = 1'b1;
            alu_op = ALU_SUB;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_b     = DM_OUT_DATA;
        acc_we    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
        if (opc == OP_ADD)      alu_op = ALU_ADD;
        else if (opc == OP_SUB) alu_op = ALU_SUB;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign PROG_ADDR  = pc;
  assign DM_RD      = dm_rd;
  assign DM_WR      = dm_wr;
  assign DM_ADDR    = (dm_rd || dm_wr) ? operand : '0;
  assign DM_IN_DATA = acc;
  assign ACC        = acc;
  assign HALTED     = (state == S_HALT);
  assign CYCLE_CNT  = cycle_cnt;

endmodule

// File: tb/tb_bip_cpu.sv
// Testbench for bip_cpu: directed programs plus random programs checked against an ISA-level model.
module tb_bip_cpu;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic        DM_RD, DM_WR;
  logic [10:0] DM_ADDR;
  logic [15:0] DM_IN_DATA;
  logic [15:0] DM_OUT_DATA;
  logic [15:0] ACC;
  logic        HALTED;
  logic [15:0] CYCLE_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rom  [0:2047];
  logic [15:0] dmem [0:2047];

  logic [26:0] obs_wr[$], exp_wr[$];
  logic [10:0] obs_rd[$], exp_rd[$];
  logic [15:0] obs_acc[$], exp_acc[$];
  logic [10:0] obs_pa[$], exp_pa[$];
  logic [15:0] acc_prev, exp_acc_final, exp_cyc;
  logic [10:0] pa_prev;
  int          overlap, idle_bad;
  bit          wrap_seen;

  bip_cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PROG_ADDR   (PROG_ADDR),
    .PROG_DATA   (PROG_DATA),
    .DM_RD       (DM_RD),
    .DM_WR       (DM_WR),
    .DM_ADDR     (DM_ADDR),
    .DM_IN_DATA  (DM_IN_DATA),
    .DM_OUT_DATA (DM_OUT_DATA),
    .ACC         (ACC),
    .HALTED      (HALTED),
    .CYCLE_CNT   (CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  // synchronous ROM and DataMemory environment
  always @(posedge CLK) begin
    PROG_DATA <= rom[PROG_ADDR];
    if (DM_WR) dmem[DM_ADDR] <= DM_IN_DATA;
    if (DM_RD) DM_OUT_DATA <= dmem[DM_ADDR];
  end

  always @(negedge CLK) begin
    if (DM_WR) obs_wr.push_back({DM_ADDR, DM_IN_DATA});
    if (DM_RD) obs_rd.push_back(DM_ADDR);
    if (DM_RD && DM_WR) overlap++;
    if (!DM_RD && !DM_WR && DM_ADDR != 11'd0) idle_bad++;
    if (ACC !== acc_prev) begin
      obs_acc.push_back(ACC);
      acc_prev = ACC;
    end
    if (PROG_ADDR !== pa_prev) begin
      if (pa_prev == 11'd2047 && PROG_ADDR == 11'd0) wrap_seen = 1'b1;
      obs_pa.push_back(PROG_ADDR);
      pa_prev = PROG_ADDR;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int operand);
    logic [4:0]  o;
    logic [10:0] a;
    o = 5'(op);
    a = 11'(operand);
    return {o, a};
  endfunction

  function automatic logic [15:0] rand_instr();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return enc(1, $urandom_range(0, 7));
      1: return enc(2, $urandom_range(0, 7));
      2: return enc(3, $urandom_range(0, 2047));
      3: return enc(4, $urandom_range(0, 7));
      4: return enc(5, $urandom_range(0, 2047));
      5: return enc(6, $urandom_range(0, 7));
      6: return enc(7, $urandom_range(0, 2047));
      default: return enc($urandom_range(8, 31), $urandom_range(0, 2047));
    endcase
  endfunction

  task automatic clear_rom();
    for (int k = 0; k < 2048; k++) rom[k] = 16'h0000;
  endtask

  // ISA-level interpreter: walks the ROM, tracks ACC/memory, tallies cycles per instruction.
  task automatic model_run();
    logic [10:0] pc;
    logic [15:0] acc, ir, sx, prev;
    logic [15:0] md [0:2047];
    int          cyc;
    bit          done;
    pc = 0; acc = 0; prev = 0; cyc = 0; done = 0;
    for (int k = 0; k < 2048; k++) md[k] = dmem[k];
    exp_wr.delete(); exp_rd.delete(); exp_acc.delete(); exp_pa.delete();
    for (int step = 0; step < 4096 && !done; step++) begin
      ir = rom[pc];
      sx = {{5{ir[10]}}, ir[10:0]};
      case (ir[15:11])
        5'd0: begin cyc += 3; done = 1; end
        5'd1: begin cyc += 3; exp_wr.push_back({ir[10:0], acc}); md[ir[10:0]] = acc; end
        5'd2: begin cyc += 4; exp_rd.push_back(ir[10:0]); acc = md[ir[10:0]]; end
        5'd3: begin cyc += 3; acc = sx; end
        5'd4: begin cyc += 4; exp_rd.push_back(ir[10:0]); acc = acc + md[ir[10:0]]; end
        5'd5: begin cyc += 3; acc = acc + sx; end
        5'd6: begin cyc += 4; exp_rd.push_back(ir[10:0]); acc = acc - md[ir[10:0]]; end
        5'd7: begin cyc += 3; acc = acc - sx; end
        default: cyc += 3;
      endcase
      if (!done) begin
        pc = pc + 11'd1;
        exp_pa.push_back(pc);
        if (acc !== prev) begin
          exp_acc.push_back(acc);
          prev = acc;
        end
      end
    end
    exp_acc_final = acc;
    exp_cyc       = 16'(cyc);
  endtask

  task automatic start_run();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    obs_wr.delete(); obs_rd.delete(); obs_acc.delete(); obs_pa.delete();
    acc_prev = 16'h0; pa_prev = 11'h0; overlap = 0; idle_bad = 0; wrap_seen = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int c;
    c = 0;
    while (!HALTED && c < budget) begin
      @(negedge CLK);
      c++;
    end
    chk($sformatf("%s_halted", tag), 32'(HALTED), 32'd1);
  endtask

  task automatic run_and_check(input string tag);
    int n, w0, r0;
    model_run();
    start_run();
    wait_halt(tag, 20000);
    chk($sformatf("%s_cycles", tag), 32'(CYCLE_CNT), 32'(exp_cyc));
    chk($sformatf("%s_acc", tag), 32'(ACC), 32'(exp_acc_final));
    chk($sformatf("%s_wr_cnt", tag), 32'(obs_wr.size()), 32'(exp_wr.size()));
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), 32'(obs_wr[i]), 32'(exp_wr[i]));
    chk($sformatf("%s_rd_cnt", tag), 32'(obs_rd.size()), 32'(exp_rd.size()));
    n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_rd%0d", tag, i), 32'(obs_rd[i]), 32'(exp_rd[i]));
    chk($sformatf("%s_acc_steps", tag), 32'(obs_acc.size()), 32'(exp_acc.size()));
    n = (obs_acc.size() < exp_acc.size()) ? obs_acc.size() : exp_acc.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_acc%0d", tag, i), 32'(obs_acc[i]), 32'(exp_acc[i]));
    chk($sformatf("%s_pc_steps", tag), 32'(obs_pa.size()), 32'(exp_pa.size()));
    n = (obs_pa.size() < exp_pa.size()) ? obs_pa.size() : exp_pa.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_pc%0d", tag, i), 32'(obs_pa[i]), 32'(exp_pa[i]));
    chk($sformatf("%s_rd_wr_overlap", tag), 32'(overlap), 32'd0);
    chk($sformatf("%s_idle_addr", tag), 32'(idle_bad), 32'd0);
    w0 = obs_wr.size();
    r0 = obs_rd.size();
    repeat (20) @(negedge CLK);
    chk($sformatf("%s_cycles_frozen", tag), 32'(CYCLE_CNT), 32'(exp_cyc));
    chk($sformatf("%s_halt_no_strobe", tag), 32'(obs_wr.size() + obs_rd.size()), 32'(w0 + r0));
    chk($sformatf("%s_still_halted", tag), 32'(HALTED), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) dmem[k] = 16'h0;
    clear_rom();
    acc_prev = 16'h0; pa_prev = 11'h0; overlap = 0; idle_bad = 0; wrap_seen = 1'b0;

    // reset state
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_pc", 32'(PROG_ADDR), 32'd0);
    chk("rst_acc", 32'(ACC), 32'd0);
    chk("rst_cycles", 32'(CYCLE_CNT), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_strobes", 32'({DM_RD, DM_WR}), 32'd0);
    chk("rst_dm_addr", 32'(DM_ADDR), 32'd0);

    // 1: LDI 5; STO 1; HLT
    clear_rom();
    rom[0] = enc(3, 5); rom[1] = enc(1, 1); rom[2] = 16'h0000;
    run_and_check("t1");
    chk("t1_cycles_const", 32'(CYCLE_CNT), 32'd9);

    // 2: immediate arithmetic with sign extension
    clear_rom();
    rom[0] = enc(3, 11'h7FF); rom[1] = enc(5, 2); rom[2] = enc(7, 11'h400); rom[3] = 16'h0000;
    run_and_check("t2");
    chk("t2_acc_const", 32'(ACC), 32'h0401);

    // 3: memory operands
    clear_rom();
    dmem[3] = 16'h0010;
    rom[0] = enc(3, 4); rom[1] = enc(4, 3); rom[2] = enc(6, 3); rom[3] = enc(2, 3); rom[4] = 16'h0000;
    run_and_check("t3");
    chk("t3_cycles_const", 32'(CYCLE_CNT), 32'd18);

    // 4: unknown opcode behaves as NOP
    clear_rom();
    rom[0] = 16'hF800; rom[1] = 16'h0000;
    run_and_check("t4");
    chk("t4_cycles_const", 32'(CYCLE_CNT), 32'd6);

    // 5: reset asserted mid-cycle during the STO execute cycle
    clear_rom();
    rom[0] = enc(3, 7); rom[1] = enc(1, 2); rom[2] = 16'h0000;
    dmem[2] = 16'h0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    chk("t5_wr_before_reset", 32'(DM_WR), 32'd1);
    RESET = 1'b1;
    #1;
    chk("t5_wr_dropped", 32'(DM_WR), 32'd0);
    chk("t5_pc_reset", 32'(PROG_ADDR), 32'd0);
    chk("t5_acc_reset", 32'(ACC), 32'd0);
    chk("t5_cycles_reset", 32'(CYCLE_CNT), 32'd0);
    @(negedge CLK);
    run_and_check("t5");

    // random programs against the ISA model
    for (int p = 0; p < 4; p++) begin
      clear_rom();
      for (int a = 0; a < 8; a++) dmem[a] = 16'($urandom);
      for (int i = 0; i < 12; i++) rom[i] = rand_instr();
      rom[12] = 16'h0000;
      run_and_check($sformatf("rnd%0d", p));
    end

    // 6: PC wrap; HLT appears at address 0 only after the PC has left it
    for (int k = 0; k < 2048; k++) rom[k] = 16'h4000;
    start_run();
    begin
      int c;
      c = 0;
      while (PROG_ADDR == 11'd0 && c < 20) begin
        @(negedge CLK);
        c++;
      end
      chk("t6_left_zero", 32'(PROG_ADDR != 11'd0), 32'd1);
    end
    rom[0] = 16'h0000;
    wait_halt("t6", 8000);
    chk("t6_wrap", 32'(wrap_seen), 32'd1);
    chk("t6_cycles", 32'(CYCLE_CNT), 32'd6147);
    chk("t6_no_strobes", 32'(obs_wr.size() + obs_rd.size()), 32'd0);
    chk("t6_acc", 32'(ACC), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
